// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, multi-cycle divide stall,
// exception flush priority and a free-running stall-cycle performance counter.
module hazard_stall_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        r1_r_id,
    input  logic        r2_r_id,
    input  logic [4:0]  r1_id,
    input  logic [4:0]  r2_id,
    input  logic [4:0]  rw_ex,
    input  logic        mem_read_ex,
    input  logic [4:0]  rw_mem,
    input  logic        mem_read_mem,
    input  logic        div_start_ex,
    input  logic        exc_flush,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        flush_all,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_BUSY  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic in_busy_s;
    logic cnt_zero_s;
    logic div_stall_s;
    logic div_done_s;
    logic lu_s;
    logic stall_s;

    // A producer in a later stage only matters if it writes a real register the ID reads.
    function automatic logic load_use(
        input logic       is_load,
        input logic [4:0] rw,
        input logic       rd1,
        input logic [4:0] rs1,
        input logic       rd2,
        input logic [4:0] rs2
    );
        return is_load & (rw != 5'd0) & ((rd1 & (rs1 == rw)) | (rd2 & (rs2 == rw)));
    endfunction

    // Hazard detection and stall/bubble priority: flush beats divide beats load-use.
    always_comb begin
        in_busy_s   = (state_q == ST_BUSY);
        cnt_zero_s  = (cnt_q == CNT_ZERO);
        div_stall_s = ~exc_flush & ((~in_busy_s & div_start_ex) | (in_busy_s & ~cnt_zero_s));
        div_done_s  = in_busy_s & cnt_zero_s & ~exc_flush;
        lu_s        = (load_use(mem_read_ex, rw_ex, r1_r_id, r1_id, r2_r_id, r2_id) |
                       load_use(mem_read_mem, rw_mem, r1_r_id, r1_id, r2_r_id, r2_id)) &
                      ~div_stall_s & ~exc_flush;
        stall_s     = div_stall_s | lu_s;
    end

    // Divider occupancy FSM; the issue cycle already counts as the first stall cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_start_ex) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q;
                    end
                end
                ST_BUSY: begin
                    if (cnt_zero_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Performance counter wraps naturally at 2^32.
    always_comb begin
        if (stall_s) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_ZERO;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_pc     = stall_s;
    assign stall_if_id  = stall_s;
    assign stall_id_ex  = div_stall_s;
    assign bubble_ex    = lu_s;
    assign bubble_mem   = div_stall_s;
    assign flush_all    = exc_flush;
    assign div_busy     = in_busy_s;
    assign div_done     = div_done_s;
    assign stall_cycles = stall_cycles_q;

endmodule
